// File: rtl/display_word_tx_if.sv
// Valid/ready word handshake into the display link transmitter.
// The sender (master) drives the word and inject flag; the transmitter
// (slave) answers with ready_out.
interface display_word_tx_if;
  logic [4:0] data_in;
  logic       valid_in;
  logic       err_inject;
  logic       ready_out;

  modport master (
    output data_in,
    output valid_in,
    output err_inject,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    input  err_inject,
    output ready_out
  );
endinterface : display_word_tx_if

// File: rtl/display_word_tx.sv
// Transmit end of the 5-bit + parity display link.
// Latches an accepted word onto the parallel bus b1..b5/b_par and serialises
// start, b1..b5, parity, stop on tx, each bit lasting CLKS_PER_BIT cycles.
module display_word_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  display_word_tx_if.slave   link,
  output logic               b1,
  output logic               b2,
  output logic               b3,
  output logic               b4,
  output logic               b5,
  output logic               b_par,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  // +1 keeps the width at least 1 bit when CLKS_PER_BIT is 1.
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic          ODD_BIT    = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [4:0]    shift_q,   shift_d;
  logic          par_q,     par_d;
  logic [4:0]    bus_q,     bus_d;
  logic          b_par_q,   b_par_d;
  logic          tx_q,      tx_d;

  logic idle;
  logic accept;
  logic expire;

  assign idle           = (state_q == S_IDLE);
  assign link.ready_out = idle && !rst;
  assign busy           = !idle && !rst;
  assign accept         = link.valid_in && link.ready_out;
  assign expire         = (timer_q == TIMER_LAST);
  assign done           = (state_q == S_STOP) && expire;

  assign {b1, b2, b3, b4, b5} = bus_q;
  assign b_par                = b_par_q;
  assign tx                   = tx_q;

  // Next-state logic: FSM, bit timer, frame shifter and parallel bus capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bus_d     = bus_q;
    b_par_d   = b_par_q;

    // The timer free-runs inside a bit and clears whenever the bit ends.
    if (idle) begin
      timer_d = '0;
    end else if (expire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = link.data_in;
          par_d   = (^link.data_in) ^ ODD_BIT ^ link.err_inject;
          bus_d   = link.data_in;
          b_par_d = par_d;
        end
      end
      S_START: begin
        if (expire) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (expire) begin
          if (bit_idx_q == 3'd4) begin
            state_d   = S_PARITY;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {shift_q[3:0], 1'b0};
          end
        end
      end
      S_PARITY: begin
        if (expire) state_d = S_STOP;
      end
      S_STOP: begin
        if (expire) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx is registered from the next state so the line changes with the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[4];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 5'd0;
      par_q     <= 1'b0;
      bus_q     <= 5'd0;
      b_par_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bus_q     <= bus_d;
      b_par_q   <= b_par_d;
      tx_q      <= tx_d;
    end
  end

endmodule : display_word_tx
